// File: rtl/fifo_sync_circular_flags_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_circular_flags_if
// Brief    : Producer/consumer bus for the single-clock circular FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_sync_circular_flags_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int LVL_WIDTH = $clog2(DEPTH + 1);

    logic                 flush_in;
    logic                 clear_err_in;
    logic                 write_in;
    logic [WIDTH-1:0]     data_write_in;
    logic                 read_in;
    logic [WIDTH-1:0]     data_read_out;
    logic                 data_valid_out;
    logic                 full_out;
    logic                 empty_out;
    logic                 almost_full_out;
    logic                 almost_empty_out;
    logic [LVL_WIDTH-1:0] level_out;
    logic                 overflow_out;
    logic                 underflow_out;

    modport master (
        output flush_in, clear_err_in, write_in, data_write_in, read_in,
        input  data_read_out, data_valid_out, full_out, empty_out,
               almost_full_out, almost_empty_out, level_out,
               overflow_out, underflow_out
    );

    modport slave (
        input  flush_in, clear_err_in, write_in, data_write_in, read_in,
        output data_read_out, data_valid_out, full_out, empty_out,
               almost_full_out, almost_empty_out, level_out,
               overflow_out, underflow_out
    );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_circular_flags.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_circular_flags
// Brief    : Single-clock circular FIFO, any depth, standard or FWFT read,
//            level, almost flags, sticky errors and synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_circular_flags #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int LVL_WIDTH     = $clog2(DEPTH + 1)
) (
    input wire logic                  clk_in,
    input wire logic                  rst_in,
    fifo_sync_circular_flags_if.slave bus
);
    localparam int                   c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0]   c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [LVL_WIDTH-1:0] c_LVL_FULL = LVL_WIDTH'(DEPTH);
    localparam logic [LVL_WIDTH-1:0] c_LVL_AF   = LVL_WIDTH'(AFULL_THRESH);
    localparam logic [LVL_WIDTH-1:0] c_LVL_AE   = LVL_WIDTH'(AEMPTY_THRESH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [LVL_WIDTH-1:0] r_level;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_afull;
    logic                 r_aempty;
    logic                 r_ovf;
    logic                 r_udf;

    logic                 w_wr_en;
    logic                 w_rd_en;
    logic                 w_ovf_set;
    logic                 w_udf_set;
    logic [c_PTR_W-1:0]   w_wptr_nxt;
    logic [c_PTR_W-1:0]   w_rptr_nxt;
    logic [LVL_WIDTH-1:0] w_level_nxt;

    // Acceptance uses this cycle's registered flags; flush overrides both sides.
    assign w_wr_en   = bus.write_in & ~r_full  & ~bus.flush_in;
    assign w_rd_en   = bus.read_in  & ~r_empty & ~bus.flush_in;
    assign w_ovf_set = bus.write_in &  r_full  & ~bus.flush_in;
    assign w_udf_set = bus.read_in  &  r_empty & ~bus.flush_in;

    always_comb begin
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_level_nxt = r_level;
        if (bus.flush_in) begin
            w_wptr_nxt  = '0;
            w_rptr_nxt  = '0;
            w_level_nxt = '0;
        end else begin
            if (w_wr_en) begin
                w_wptr_nxt = (r_wptr == c_PTR_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_rd_en) begin
                w_rptr_nxt = (r_rptr == c_PTR_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   w_level_nxt = r_level + LVL_WIDTH'(1);
                2'b01:   w_level_nxt = r_level - LVL_WIDTH'(1);
                default: w_level_nxt = r_level;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= bus.data_write_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wptr   <= w_wptr_nxt;
            r_rptr   <= w_rptr_nxt;
            r_level  <= w_level_nxt;
            r_full   <= (w_level_nxt == c_LVL_FULL);
            r_empty  <= (w_level_nxt == '0);
            r_afull  <= (w_level_nxt >= c_LVL_AF);
            r_aempty <= (w_level_nxt <= c_LVL_AE);
            // A new error event in the clearing cycle keeps the flag set.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (bus.clear_err_in) begin
                r_ovf <= 1'b0;
            end
            if (w_udf_set) begin
                r_udf <= 1'b1;
            end else if (bus.clear_err_in) begin
                r_udf <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; zero while nothing is stored.
            assign bus.data_read_out  = r_empty ? '0 : r_mem[r_rptr];
            assign bus.data_valid_out = ~r_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_dout;
            logic             r_dvalid;

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    r_dout   <= '0;
                    r_dvalid <= 1'b0;
                end else begin
                    r_dvalid <= w_rd_en;
                    if (w_rd_en) begin
                        r_dout <= r_mem[r_rptr];
                    end
                end
            end

            assign bus.data_read_out  = r_dout;
            assign bus.data_valid_out = r_dvalid;
        end
    endgenerate

    assign bus.full_out         = r_full;
    assign bus.empty_out        = r_empty;
    assign bus.almost_full_out  = r_afull;
    assign bus.almost_empty_out = r_aempty;
    assign bus.level_out        = r_level;
    assign bus.overflow_out     = r_ovf;
    assign bus.underflow_out    = r_udf;
endmodule
`default_nettype wire
